// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: the core<->memory handshake
// structs, the responder state encoding and lane helper functions.
package dmem_responder_pkg;

  localparam int          data_mem_addr_width_gp = 12;
  localparam logic [15:0] dmem_lfsr_seed_gc      = 16'hACE1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] dmem_lfsr_taps_gc      = 16'hB400;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    DMEM_R_IDLE = 2'b00,
    DMEM_R_WAIT = 2'b01,
    DMEM_R_RESP = 2'b10
  } dmem_resp_state_e;

  // Byte-write enable: all lanes for a word, one little-endian lane for a byte
  function automatic logic [3:0] dmem_byte_en(input logic byte_not_word,
                                              input logic [1:0] lane);
    logic [3:0] be;
    if (byte_not_word) begin
      case (lane)
        2'd0:    be = 4'b0001;
        2'd1:    be = 4'b0010;
        2'd2:    be = 4'b0100;
        2'd3:    be = 4'b1000;
        default: be = 4'b0000;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Read formatting: full word, or the addressed lane zero-extended (LBU)
  function automatic logic [31:0] dmem_lane_extract(input logic [31:0] word,
                                                    input logic        byte_not_word,
                                                    input logic [1:0]  lane);
    logic [31:0] res;
    if (byte_not_word) begin
      case (lane)
        2'd0:    res = {24'h000000, word[7:0]};
        2'd1:    res = {24'h000000, word[15:8]};
        2'd2:    res = {24'h000000, word[23:16]};
        2'd3:    res = {24'h000000, word[31:24]};
        default: res = 32'h00000000;
      endcase
    end else begin
      res = word;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// Single-port 32-bit-wide RAM with per-byte write enables and a registered
// read port. A cycle with en_i and no write enables is a read.
module dmem_ram_1rw #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk_i,
  input  logic                    n_reset_i,
  input  logic                    en_i,
  input  logic [3:0]              we_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  localparam int depth_lp = 1 << addr_width_p;

  logic [31:0] mem_q [depth_lp];
  logic [31:0] rdata_q;

  // Commit byte-enabled writes; the array contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read; the output holds until the next read cycle
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      rdata_q <= 32'h00000000;
    end else if (en_i && (we_i == 4'b0000)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the core<->data-memory handshake. Accepts one request at a
// time (combinational yumi while idle), commits writes on the accept edge,
// waits the configured latency and then holds the response until the core
// consumes it.
// Optional build macro: DMEM_RAND_STALL_EN adds 0-3 LFSR-driven extra wait
// cycles per request.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int addr_width_p = data_mem_addr_width_gp,
  parameter int latency_p    = 1
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  mem_in_s                 mem_in_i,
  input  logic [addr_width_p-1:0] addr_i,
  output mem_out_s                mem_out_o,
  output logic                    busy_o
);

`ifdef DMEM_RAND_STALL_EN
  localparam int max_lat_lp = latency_p + 3;
`else
  localparam int max_lat_lp = latency_p;
`endif
  localparam int cnt_w_lp = (max_lat_lp < 2) ? 1 : $clog2(max_lat_lp);
  localparam int lat_w_lp = cnt_w_lp + 1;

  dmem_resp_state_e            state_q, state_d;
  logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
  logic [addr_width_p-1:0]     addr_q;
  logic                        wen_q;
  logic                        bnw_q;
  logic                        accept_s;
  logic [lat_w_lp-1:0]         lat_s;

  logic                        ram_en_s;
  logic [3:0]                  ram_we_s;
  logic [addr_width_p-3:0]     ram_addr_s;
  logic [31:0]                 ram_wdata_s;
  logic [31:0]                 ram_rdata_s;
  logic                        read_entry_s;

  assign accept_s = mem_in_i.valid & (state_q == DMEM_R_IDLE);

`ifdef DMEM_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR step, advanced every cycle regardless of traffic
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? dmem_lfsr_taps_gc : 16'h0000);
  end

  // Stall LFSR register, reseeded on reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lfsr_q <= dmem_lfsr_seed_gc;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lat_s = lat_w_lp'(latency_p) + lat_w_lp'(lfsr_q[1:0]);
`else
  assign lat_s = lat_w_lp'(latency_p);
`endif

  // State and latency counter registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= DMEM_R_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, countdown to zero, hold until core yumi
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_R_IDLE: begin
        if (accept_s) begin
          if (lat_s == lat_w_lp'(1)) begin
            state_d = DMEM_R_RESP;
            cnt_d   = '0;
          end else begin
            state_d = DMEM_R_WAIT;
            cnt_d   = cnt_w_lp'(lat_s - lat_w_lp'(1));
          end
        end else begin
          state_d = DMEM_R_IDLE;
          cnt_d   = cnt_q;
        end
      end
      DMEM_R_WAIT: begin
        // The decrement that lands on zero is the transition into RESP
        if (cnt_q <= cnt_w_lp'(1)) begin
          state_d = DMEM_R_RESP;
          cnt_d   = '0;
        end else begin
          state_d = DMEM_R_WAIT;
          cnt_d   = cnt_q - cnt_w_lp'(1);
        end
      end
      DMEM_R_RESP: begin
        if (mem_in_i.yumi) begin
          state_d = DMEM_R_IDLE;
        end else begin
          state_d = DMEM_R_RESP;
        end
      end
      default: begin
        state_d = DMEM_R_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Capture the accepted request's address and type for the response phase
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_q <= '0;
      wen_q  <= 1'b0;
      bnw_q  <= 1'b0;
    end else if (accept_s) begin
      addr_q <= addr_i;
      wen_q  <= mem_in_i.wen;
      bnw_q  <= mem_in_i.byte_not_word;
    end
  end

  // RAM port: writes use the live request on accept; reads fire on RESP entry
  always_comb begin
    read_entry_s = (state_d == DMEM_R_RESP) && (state_q != DMEM_R_RESP) &&
                   !(accept_s ? mem_in_i.wen : wen_q);
    if (accept_s && mem_in_i.wen) begin
      ram_we_s = dmem_byte_en(mem_in_i.byte_not_word, addr_i[1:0]);
    end else begin
      ram_we_s = 4'b0000;
    end
    ram_en_s    = (accept_s && mem_in_i.wen) || read_entry_s;
    ram_addr_s  = accept_s ? addr_i[addr_width_p-1:2] : addr_q[addr_width_p-1:2];
    ram_wdata_s = mem_in_i.byte_not_word ? {4{mem_in_i.write_data[7:0]}}
                                         : mem_in_i.write_data;
  end

  dmem_ram_1rw #(
    .addr_width_p (addr_width_p - 2)
  ) u_ram (
    .clk_i     (clk),
    .n_reset_i (n_reset),
    .en_i      (ram_en_s),
    .we_i      (ram_we_s),
    .addr_i    (ram_addr_s),
    .wdata_i   (ram_wdata_s),
    .rdata_o   (ram_rdata_s)
  );

  // Outputs: response valid/data from state, accept strobe, busy flag
  always_comb begin
    mem_out_o.valid = (state_q == DMEM_R_RESP);
    mem_out_o.yumi  = accept_s;
    if ((state_q == DMEM_R_RESP) && !wen_q) begin
      mem_out_o.read_data = dmem_lane_extract(ram_rdata_s, bnw_q, addr_q[1:0]);
    end else begin
      mem_out_o.read_data = 32'h00000000;
    end
    busy_o = (state_q != DMEM_R_IDLE);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at latency 1, one at
// latency 3, driven through a shared stimulus bus selected by 'sel'.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        sel;
  mem_in_s     drv;
  logic [11:0] addr_tb;
  mem_in_s     in1, in3;
  logic [11:0] a1, a3;
  mem_out_s    out1, out3, out_s;
  logic        busy1, busy3, busy_s;
  int          checks = 0;
  int          errors = 0;

  assign in1    = sel ? '0 : drv;
  assign in3    = sel ? drv : '0;
  assign a1     = sel ? 12'h000 : addr_tb;
  assign a3     = sel ? addr_tb : 12'h000;
  assign out_s  = sel ? out3 : out1;
  assign busy_s = sel ? busy3 : busy1;

  dmem_responder #(.addr_width_p(12), .latency_p(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .mem_in_i(in1), .addr_i(a1),
    .mem_out_o(out1), .busy_o(busy1));

  dmem_responder #(.addr_width_p(12), .latency_p(3)) dut3 (
    .clk(clk), .n_reset(n_reset), .mem_in_i(in3), .addr_i(a3),
    .mem_out_o(out3), .busy_o(busy3));

  // Wait (bounded) for response valid; lat counts cycles after the accept edge
  task automatic wait_resp(output int lat);
    lat = 1;
    while (out_s.valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_txn(input logic wen, input logic bnw, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp,
                        input int exp_lat, input string name, output int lat);
    bit lat_ok;
    @(negedge clk);
    drv.valid = 1'b1; drv.wen = wen; drv.byte_not_word = bnw;
    drv.write_data = wdata; addr_tb = addr;
    #1;
    checks++;
    if (out_s.yumi !== 1'b1) begin
      errors++; $display("FAIL %s yumi: got %b expected 1", name, out_s.yumi);
    end
    @(negedge clk);
    drv.valid = 1'b0;
    wait_resp(lat);
`ifdef DMEM_RAND_STALL_EN
    lat_ok = (lat >= exp_lat) && (lat <= exp_lat + 3);
`else
    lat_ok = (lat == exp_lat);
`endif
    checks++;
    if (!lat_ok) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_s.read_data !== exp) begin
      errors++; $display("FAIL %s read_data: got %h expected %h", name, out_s.read_data, exp);
    end
    drv.yumi = 1'b1;
    @(negedge clk);
    drv.yumi = 1'b0;
    #1;
    checks++;
    if (out_s.valid !== 1'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL %s release: got valid=%b busy=%b expected 0/0", name, out_s.valid, busy_s);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; sel = 1'b0; drv = '0; addr_tb = 12'h000;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if (out_s.valid !== 1'b0 || out_s.yumi !== 1'b0) begin
        errors++; $display("FAIL reset_handshake dut%0d: got valid=%b yumi=%b expected 0/0", s, out_s.valid, out_s.yumi);
      end
      checks++;
      if (out_s.read_data !== 32'h00000000) begin
        errors++; $display("FAIL reset_rdata dut%0d: got %h expected 0", s, out_s.read_data);
      end
      checks++;
      if (busy_s !== 1'b0) begin
        errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", s, busy_s);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_word_rw();
    int lat;
    sel = 1'b0;
    do_txn(1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1, "sw_word", lat);
    do_txn(1'b0, 1'b0, 12'h010, 32'h00000000, 32'hDEADBEEF, 1, "lw_word", lat);
    do_txn(1'b1, 1'b0, 12'h017, 32'h01234567, 32'h00000000, 1, "sw_unaligned", lat);
    do_txn(1'b0, 1'b0, 12'h014, 32'h00000000, 32'h01234567, 1, "lw_unaligned", lat);
    do_txn(1'b0, 1'b0, 12'h012, 32'h00000000, 32'hDEADBEEF, 1, "lw_neighbour", lat);
  endtask

  task automatic test_byte_lanes();
    int lat;
    sel = 1'b0;
    do_txn(1'b1, 1'b0, 12'h020, 32'h11223344, 32'h00000000, 1, "sw_lanes", lat);
    do_txn(1'b1, 1'b1, 12'h022, 32'hFFFFFFAA, 32'h00000000, 1, "sb_lane2", lat);
    do_txn(1'b0, 1'b0, 12'h020, 32'h00000000, 32'h11AA3344, 1, "lw_after_sb", lat);
    do_txn(1'b0, 1'b1, 12'h023, 32'h00000000, 32'h00000011, 1, "lbu_lane3", lat);
    do_txn(1'b0, 1'b1, 12'h020, 32'h00000000, 32'h00000044, 1, "lbu_lane0", lat);
    do_txn(1'b0, 1'b1, 12'h022, 32'h00000000, 32'h000000AA, 1, "lbu_lane2", lat);
    do_txn(1'b1, 1'b1, 12'h021, 32'h123456F0, 32'h00000000, 1, "sb_lane1", lat);
    do_txn(1'b0, 1'b0, 12'h020, 32'h00000000, 32'h11AAF044, 1, "lw_after_sb1", lat);
  endtask

  task automatic test_backpressure();
    int lat;
    bit lat_ok;
    sel = 1'b1;
    do_txn(1'b1, 1'b0, 12'h040, 32'h5A5AC3C3, 32'h00000000, 3, "bp_sw", lat);
    @(negedge clk);
    drv.valid = 1'b1; drv.wen = 1'b0; drv.byte_not_word = 1'b0; addr_tb = 12'h040;
    #1;
    checks++;
    if (out_s.yumi !== 1'b1) begin
      errors++; $display("FAIL bp_lw_yumi: got %b expected 1", out_s.yumi);
    end
    @(negedge clk);
    drv.valid = 1'b0;
    wait_resp(lat);
`ifdef DMEM_RAND_STALL_EN
    lat_ok = (lat >= 3) && (lat <= 6);
`else
    lat_ok = (lat == 3);
`endif
    checks++;
    if (!lat_ok) begin
      errors++; $display("FAIL bp_latency: got %0d expected 3", lat);
    end
    // Second request (SW) presented while the response is withheld
    drv.valid = 1'b1; drv.wen = 1'b1; drv.write_data = 32'h77777777; addr_tb = 12'h044;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++;
      if (out_s.valid !== 1'b1 || out_s.read_data !== 32'h5A5AC3C3 || out_s.yumi !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d: got valid=%b data=%h yumi=%b expected 1/5a5ac3c3/0",
                           c, out_s.valid, out_s.read_data, out_s.yumi);
      end
    end
    @(negedge clk);
    drv.yumi = 1'b1;
    #1;
    checks++;
    if (out_s.yumi !== 1'b0) begin
      errors++; $display("FAIL bp_yumi_same_cycle: got %b expected 0", out_s.yumi);
    end
    @(negedge clk);
    drv.yumi = 1'b0;
    #1;
    checks++;
    if (out_s.valid !== 1'b0 || out_s.yumi !== 1'b1) begin
      errors++; $display("FAIL bp_second_accept: got valid=%b yumi=%b expected 0/1", out_s.valid, out_s.yumi);
    end
    @(negedge clk);
    drv.valid = 1'b0;
    wait_resp(lat);
    checks++;
    if (out_s.valid !== 1'b1 || out_s.read_data !== 32'h00000000) begin
      errors++; $display("FAIL bp_second_resp: got valid=%b data=%h expected 1/0", out_s.valid, out_s.read_data);
    end
    drv.yumi = 1'b1;
    @(negedge clk);
    drv.yumi = 1'b0;
    do_txn(1'b0, 1'b0, 12'h044, 32'h00000000, 32'h77777777, 3, "bp_readback", lat);
  endtask

  task automatic test_reset_mid_op();
    int lat;
    sel = 1'b1;
    do_txn(1'b1, 1'b0, 12'h100, 32'h0A5A5A5A, 32'h00000000, 3, "rst_prep_sw", lat);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv.valid = 1'b1; drv.byte_not_word = 1'b0;
      drv.wen = (k == 1); drv.write_data = 32'hCAFEF00D;
      addr_tb = (k == 1) ? 12'h104 : 12'h100;
      @(negedge clk);
      drv.valid = 1'b0;
      #1;
      checks++;
      if (busy_s !== 1'b1 || out_s.valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_wait%0d: got busy=%b valid=%b expected 1/0", k, busy_s, out_s.valid);
      end
      n_reset = 1'b0;
      #1;
      checks++;
      if (out_s.valid !== 1'b0 || busy_s !== 1'b0 || out_s.read_data !== 32'h00000000) begin
        errors++; $display("FAIL rst_mid_drop%0d: got valid=%b busy=%b data=%h expected 0/0/0",
                           k, out_s.valid, busy_s, out_s.read_data);
      end
      repeat (2) @(negedge clk);
      n_reset = 1'b1;
    end
    do_txn(1'b0, 1'b0, 12'h104, 32'h00000000, 32'hCAFEF00D, 3, "rst_write_kept", lat);
    do_txn(1'b0, 1'b0, 12'h100, 32'h00000000, 32'h0A5A5A5A, 3, "rst_old_kept", lat);
  endtask

`ifdef DMEM_RAND_STALL_EN
  task automatic test_rand_stall();
    logic [31:0] model [16];
    int          hist [4];
    int          lat, op, idx, lane;
    logic [31:0] wd, exp;
    logic [11:0] addr;
    sel = 1'b0;
    for (int h = 0; h < 4; h++) hist[h] = 0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model[i] = wd;
      do_txn(1'b1, 1'b0, 12'h200 + 12'(i * 4), wd, 32'h00000000, 1, "rand_init", lat);
    end
    for (int n = 0; n < 1000; n++) begin
      op   = $urandom_range(0, 3);
      idx  = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      wd   = $urandom;
      addr = 12'h200 + 12'(idx * 4) + 12'(lane);
      case (op)
        0: begin exp = model[idx]; do_txn(1'b0, 1'b0, addr, wd, exp, 1, "rand_lw", lat); end
        1: begin model[idx] = wd; do_txn(1'b1, 1'b0, addr, wd, 32'h00000000, 1, "rand_sw", lat); end
        2: begin
          model[idx][8*lane +: 8] = wd[7:0];
          do_txn(1'b1, 1'b1, addr, wd, 32'h00000000, 1, "rand_sb", lat);
        end
        default: begin
          exp = (model[idx] >> (8 * lane)) & 32'h000000FF;
          do_txn(1'b0, 1'b1, addr, wd, exp, 1, "rand_lbu", lat);
        end
      endcase
      if (lat >= 1 && lat <= 4) hist[lat-1]++;
    end
    for (int h = 0; h < 4; h++) begin
      checks++;
      if (hist[h] == 0) begin
        errors++; $display("FAIL rand_latency_%0d: got 0 hits expected >0", h + 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_backpressure();
    test_reset_mid_op();
`ifdef DMEM_RAND_STALL_EN
    test_rand_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
